// File: rtl/krnl_acc_ctrl_fsm.sv
// krnl_acc_ctrl_fsm: ap_ctrl_chain kernel sequencer (latch job cfg, IFM/WGT reads, then core + OFM write).
// Optional per-wait-state watchdog enabled by defining KRNL_ACC_CTRL_TIMEOUT_EN.
module krnl_acc_ctrl_fsm #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned SIZE_W = 32
`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
`endif
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              ap_start,
    input  logic              ap_continue,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [SIZE_W-1:0] cfg_ci,
    input  logic [SIZE_W-1:0] cfg_co,
    input  logic [SIZE_W-1:0] ifm_size,
    input  logic [SIZE_W-1:0] wgt_size,
    input  logic [SIZE_W-1:0] ofm_size,
    input  logic [ADDR_W-1:0] ifm_addr_base,
    input  logic [ADDR_W-1:0] wgt_addr_base,
    input  logic [ADDR_W-1:0] ofm_addr_base,
    output logic              ifm_rd_start,
    output logic              wgt_rd_start,
    output logic              ofm_wr_start,
    output logic [ADDR_W-1:0] ifm_rd_addr,
    output logic [ADDR_W-1:0] wgt_rd_addr,
    output logic [ADDR_W-1:0] ofm_wr_addr,
    output logic [SIZE_W-1:0] ifm_rd_size,
    output logic [SIZE_W-1:0] wgt_rd_size,
    output logic [SIZE_W-1:0] ofm_wr_size,
    input  logic              ifm_rd_done,
    input  logic              wgt_rd_done,
    input  logic              ofm_wr_done,
    output logic              core_start,
    output logic [SIZE_W-1:0] core_ci,
    output logic [SIZE_W-1:0] core_co,
    input  logic              core_done,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOAD,
        COMPUTE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              ap_done_d, ap_idle_d, ap_ready_d;
    logic              ifm_rd_start_d, wgt_rd_start_d, ofm_wr_start_d, core_start_d;
    logic [ADDR_W-1:0] ifm_rd_addr_d, wgt_rd_addr_d, ofm_wr_addr_d;
    logic [SIZE_W-1:0] ifm_rd_size_d, wgt_rd_size_d, ofm_wr_size_d;
    logic [SIZE_W-1:0] core_ci_d, core_co_d;
    logic              ifm_flag_q, ifm_flag_d, wgt_flag_q, wgt_flag_d;
    logic              core_flag_q, core_flag_d, ofm_flag_q, ofm_flag_d;
    logic              load_fin, comp_fin;

    // A done pulse in the same cycle as the last missing flag still completes the wait.
    assign load_fin = (ifm_flag_q | ifm_rd_done) & (wgt_flag_q | wgt_rd_done);
    assign comp_fin = (core_flag_q | core_done) & (ofm_flag_q | ofm_wr_done);

`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        err_q, err_d;
    logic        wd_hit;

    assign wd_hit      = (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_d        = state_q;
        ap_done_d      = ap_done;
        ap_idle_d      = ap_idle;
        ap_ready_d     = 1'b0;
        ifm_rd_start_d = 1'b0;
        wgt_rd_start_d = 1'b0;
        ofm_wr_start_d = 1'b0;
        core_start_d   = 1'b0;
        ifm_rd_addr_d  = ifm_rd_addr;
        wgt_rd_addr_d  = wgt_rd_addr;
        ofm_wr_addr_d  = ofm_wr_addr;
        ifm_rd_size_d  = ifm_rd_size;
        wgt_rd_size_d  = wgt_rd_size;
        ofm_wr_size_d  = ofm_wr_size;
        core_ci_d      = core_ci;
        core_co_d      = core_co;
        ifm_flag_d     = ifm_flag_q;
        wgt_flag_d     = wgt_flag_q;
        core_flag_d    = core_flag_q;
        ofm_flag_d     = ofm_flag_q;
`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
        wd_cnt_d       = wd_cnt_q;
        err_d          = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d    = LATCH;
                    ap_idle_d  = 1'b0;
                    ap_ready_d = 1'b1;
                end
            end
            LATCH: begin
                state_d        = LOAD;
                ifm_rd_addr_d  = ifm_addr_base;
                wgt_rd_addr_d  = wgt_addr_base;
                ofm_wr_addr_d  = ofm_addr_base;
                ifm_rd_size_d  = ifm_size;
                wgt_rd_size_d  = wgt_size;
                ofm_wr_size_d  = ofm_size;
                core_ci_d      = cfg_ci;
                core_co_d      = cfg_co;
                // Zero-size engines are skipped by presetting their done flags.
                ifm_rd_start_d = (ifm_size != '0);
                wgt_rd_start_d = (wgt_size != '0);
                ifm_flag_d     = (ifm_size == '0);
                wgt_flag_d     = (wgt_size == '0);
                core_flag_d    = 1'b0;
                ofm_flag_d     = 1'b0;
`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
                err_d          = 1'b0;
`endif
            end
            LOAD: begin
                if (ifm_rd_done) ifm_flag_d = 1'b1;
                if (wgt_rd_done) wgt_flag_d = 1'b1;
                if (load_fin) begin
                    state_d        = COMPUTE;
                    core_start_d   = 1'b1;
                    ofm_wr_start_d = (ofm_wr_size != '0);
                    core_flag_d    = 1'b0;
                    ofm_flag_d     = (ofm_wr_size == '0);
                end
`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
                else if (wd_hit) begin
                    state_d   = DONE;
                    ap_done_d = 1'b1;
                    err_d     = 1'b1;
                end
`endif
            end
            COMPUTE: begin
                if (core_done)   core_flag_d = 1'b1;
                if (ofm_wr_done) ofm_flag_d  = 1'b1;
                if (comp_fin) begin
                    state_d   = DONE;
                    ap_done_d = 1'b1;
                end
`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
                else if (wd_hit) begin
                    state_d   = DONE;
                    ap_done_d = 1'b1;
                    err_d     = 1'b1;
                end
`endif
            end
            DONE: begin
                if (ap_continue) begin
                    state_d   = IDLE;
                    ap_done_d = 1'b0;
                    ap_idle_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                ap_done_d = 1'b0;
                ap_idle_d = 1'b1;
            end
        endcase

`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
        // Watchdog restarts on entry to each wait state and counts while waiting.
        if ((state_d == LOAD || state_d == COMPUTE) && state_d != state_q)
            wd_cnt_d = '0;
        else if (state_q == LOAD || state_q == COMPUTE)
            wd_cnt_d = wd_cnt_q + 32'd1;
`endif
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            ap_done      <= 1'b0;
            ap_idle      <= 1'b1;
            ap_ready     <= 1'b0;
            ifm_rd_start <= 1'b0;
            wgt_rd_start <= 1'b0;
            ofm_wr_start <= 1'b0;
            core_start   <= 1'b0;
            ifm_rd_addr  <= '0;
            wgt_rd_addr  <= '0;
            ofm_wr_addr  <= '0;
            ifm_rd_size  <= '0;
            wgt_rd_size  <= '0;
            ofm_wr_size  <= '0;
            core_ci      <= '0;
            core_co      <= '0;
            ifm_flag_q   <= 1'b0;
            wgt_flag_q   <= 1'b0;
            core_flag_q  <= 1'b0;
            ofm_flag_q   <= 1'b0;
`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
            wd_cnt_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ap_done      <= ap_done_d;
            ap_idle      <= ap_idle_d;
            ap_ready     <= ap_ready_d;
            ifm_rd_start <= ifm_rd_start_d;
            wgt_rd_start <= wgt_rd_start_d;
            ofm_wr_start <= ofm_wr_start_d;
            core_start   <= core_start_d;
            ifm_rd_addr  <= ifm_rd_addr_d;
            wgt_rd_addr  <= wgt_rd_addr_d;
            ofm_wr_addr  <= ofm_wr_addr_d;
            ifm_rd_size  <= ifm_rd_size_d;
            wgt_rd_size  <= wgt_rd_size_d;
            ofm_wr_size  <= ofm_wr_size_d;
            core_ci      <= core_ci_d;
            core_co      <= core_co_d;
            ifm_flag_q   <= ifm_flag_d;
            wgt_flag_q   <= wgt_flag_d;
            core_flag_q  <= core_flag_d;
            ofm_flag_q   <= ofm_flag_d;
`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_krnl_acc_ctrl_fsm.sv
// Self-checking bench for krnl_acc_ctrl_fsm: job configs are queued on stimulus and checked when latched.
// Define KRNL_ACC_CTRL_TIMEOUT_EN to exercise the watchdog with TIMEOUT_CYCLES=50.
module tb_krnl_acc_ctrl_fsm;

    typedef struct packed {
        logic [63:0] ia;
        logic [63:0] wa;
        logic [63:0] oa;
        logic [31:0] isz;
        logic [31:0] wsz;
        logic [31:0] osz;
        logic [31:0] ci;
        logic [31:0] co;
    } job_t;

    logic        ACLK, ARESET;
    logic        ap_start, ap_continue, ap_done, ap_idle, ap_ready;
    logic [31:0] cfg_ci, cfg_co, ifm_size, wgt_size, ofm_size;
    logic [63:0] ifm_addr_base, wgt_addr_base, ofm_addr_base;
    logic        ifm_rd_start, wgt_rd_start, ofm_wr_start;
    logic [63:0] ifm_rd_addr, wgt_rd_addr, ofm_wr_addr;
    logic [31:0] ifm_rd_size, wgt_rd_size, ofm_wr_size;
    logic        ifm_rd_done, wgt_rd_done, ofm_wr_done;
    logic        core_start, core_done, err_timeout;
    logic [31:0] core_ci, core_co;

    job_t exp_q[$];
    job_t obs;
    int   total = 0;
    int   bad = 0;
    int   n_ifm = 0, n_wgt = 0, n_ofm = 0, n_core = 0, n_rdy = 0;

    assign obs = {ifm_rd_addr, wgt_rd_addr, ofm_wr_addr, ifm_rd_size, wgt_rd_size,
                  ofm_wr_size, core_ci, core_co};

    krnl_acc_ctrl_fsm #(
        .ADDR_W(64),
        .SIZE_W(32)
`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(32'd50)
`endif
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .cfg_ci(cfg_ci), .cfg_co(cfg_co),
        .ifm_size(ifm_size), .wgt_size(wgt_size), .ofm_size(ofm_size),
        .ifm_addr_base(ifm_addr_base), .wgt_addr_base(wgt_addr_base), .ofm_addr_base(ofm_addr_base),
        .ifm_rd_start(ifm_rd_start), .wgt_rd_start(wgt_rd_start), .ofm_wr_start(ofm_wr_start),
        .ifm_rd_addr(ifm_rd_addr), .wgt_rd_addr(wgt_rd_addr), .ofm_wr_addr(ofm_wr_addr),
        .ifm_rd_size(ifm_rd_size), .wgt_rd_size(wgt_rd_size), .ofm_wr_size(ofm_wr_size),
        .ifm_rd_done(ifm_rd_done), .wgt_rd_done(wgt_rd_done), .ofm_wr_done(ofm_wr_done),
        .core_start(core_start), .core_ci(core_ci), .core_co(core_co),
        .core_done(core_done), .err_timeout(err_timeout)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Pulse counters sampled mid-cycle.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (ifm_rd_start) n_ifm++;
            if (wgt_rd_start) n_wgt++;
            if (ofm_wr_start) n_ofm++;
            if (core_start)   n_core++;
            if (ap_ready)     n_rdy++;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_job(input job_t j);
        ifm_addr_base = j.ia;
        wgt_addr_base = j.wa;
        ofm_addr_base = j.oa;
        ifm_size      = j.isz;
        wgt_size      = j.wsz;
        ofm_size      = j.osz;
        cfg_ci        = j.ci;
        cfg_co        = j.co;
        exp_q.push_back(j);
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        tick();
        tick();
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", ap_idle); end
        total++; if ({ap_done, ap_ready, err_timeout} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {ap_done, ap_ready, err_timeout}); end
        total++; if ({ifm_rd_start, wgt_rd_start, core_start, ofm_wr_start} !== 4'b0000) begin bad++; $display("FAIL rst_starts: got %b want 0000", {ifm_rd_start, wgt_rd_start, core_start, ofm_wr_start}); end
        total++; if (obs !== '0) begin bad++; $display("FAIL rst_latched: got %h want 0", obs); end
        ARESET = 1'b0;
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        tick();
        total++; if ({ap_idle, ap_done, ap_ready} !== 3'b100) begin bad++; $display("FAIL idle_continue_ignored: got %b want 100", {ap_idle, ap_done, ap_ready}); end
    endtask

    task automatic test_nominal();
        job_t e;
        int b_ifm = n_ifm, b_wgt = n_wgt, b_ofm = n_ofm, b_core = n_core, b_rdy = n_rdy;
        set_job('{ia: 64'h1000, wa: 64'h2000, oa: 64'h3000, isz: 32'd256, wsz: 32'd64,
                  osz: 32'd128, ci: 32'd3, co: 32'd16});
        ap_start = 1'b1;
        tick();                                         // cycle 1
        total++; if ({ap_ready, ap_idle} !== 2'b10) begin bad++; $display("FAIL nom_ready: got %b want 10", {ap_ready, ap_idle}); end
        ap_start = 1'b0;
        tick();                                         // cycle 2
        total++; if ({ap_ready, ifm_rd_start, wgt_rd_start, core_start, ofm_wr_start} !== 5'b01100) begin bad++; $display("FAIL nom_load_starts: got %b want 01100", {ap_ready, ifm_rd_start, wgt_rd_start, core_start, ofm_wr_start}); end
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL nom_latched: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (obs !== e) begin bad++; $display("FAIL nom_latched: got %h want %h", obs, e); end
        end
        tick();                                         // cycle 3
        ifm_addr_base = 64'hDEAD;
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        repeat (8) tick();                              // cycle 12
        ifm_rd_done = 1'b1;
        tick();
        ifm_rd_done = 1'b0;
        repeat (9) tick();                              // cycle 22
        total++; if (n_core !== b_core) begin bad++; $display("FAIL nom_core_early: got %0d core starts want 0", n_core - b_core); end
        wgt_rd_done = 1'b1;
        tick();                                         // cycle 23
        wgt_rd_done = 1'b0;
        total++; if ({core_start, ofm_wr_start} !== 2'b11) begin bad++; $display("FAIL nom_compute_starts: got %b want 11", {core_start, ofm_wr_start}); end
        total++; if (ifm_rd_addr !== 64'h1000) begin bad++; $display("FAIL nom_addr_stable: got %h want 1000", ifm_rd_addr); end
        repeat (5) tick();
        core_done = 1'b1;
        ofm_wr_done = 1'b1;
        tick();
        core_done = 1'b0;
        ofm_wr_done = 1'b0;
        total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL nom_done: got %b want 1", ap_done); end
        repeat (3) tick();
        total++; if ({ap_done, ap_idle} !== 2'b10) begin bad++; $display("FAIL nom_done_held: got %b want 10", {ap_done, ap_idle}); end
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        total++; if ({ap_done, ap_idle} !== 2'b01) begin bad++; $display("FAIL nom_continue: got %b want 01", {ap_done, ap_idle}); end
        total++;
        if ((n_ifm - b_ifm) != 1 || (n_wgt - b_wgt) != 1 || (n_ofm - b_ofm) != 1 ||
            (n_core - b_core) != 1 || (n_rdy - b_rdy) != 1) begin
            bad++;
            $display("FAIL nom_pulse_counts: got ifm=%0d wgt=%0d ofm=%0d core=%0d rdy=%0d want all 1",
                     n_ifm - b_ifm, n_wgt - b_wgt, n_ofm - b_ofm, n_core - b_core, n_rdy - b_rdy);
        end
    endtask

    task automatic test_zero_sizes();
        job_t e;
        int b_wgt = n_wgt, b_ofm = n_ofm;
        set_job('{ia: 64'h4000, wa: 64'h5000, oa: 64'h6000, isz: 32'd32, wsz: 32'd0,
                  osz: 32'd0, ci: 32'd1, co: 32'd2});
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();                                         // cycle 2
        total++; if ({ifm_rd_start, wgt_rd_start, core_start, ofm_wr_start} !== 4'b1000) begin bad++; $display("FAIL zero_load_starts: got %b want 1000", {ifm_rd_start, wgt_rd_start, core_start, ofm_wr_start}); end
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL zero_latched: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (obs !== e) begin bad++; $display("FAIL zero_latched: got %h want %h", obs, e); end
        end
        tick();
        ifm_rd_done = 1'b1;
        tick();
        ifm_rd_done = 1'b0;
        total++; if ({core_start, ofm_wr_start} !== 2'b10) begin bad++; $display("FAIL zero_compute_starts: got %b want 10", {core_start, ofm_wr_start}); end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", ap_done); end
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        total++; if ((n_wgt - b_wgt) != 0 || (n_ofm - b_ofm) != 0) begin bad++; $display("FAIL zero_no_pulses: got wgt=%0d ofm=%0d want 0", n_wgt - b_wgt, n_ofm - b_ofm); end

        // All three sizes zero: LOAD passes straight through.
        set_job('{ia: 64'h7000, wa: 64'h7100, oa: 64'h7200, isz: 32'd0, wsz: 32'd0,
                  osz: 32'd0, ci: 32'd5, co: 32'd6});
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();                                         // cycle 2
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL allzero_latched: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (obs !== e) begin bad++; $display("FAIL allzero_latched: got %h want %h", obs, e); end
        end
        tick();                                         // cycle 3
        total++; if ({ifm_rd_start, wgt_rd_start, core_start, ofm_wr_start} !== 4'b0010) begin bad++; $display("FAIL allzero_core_start: got %b want 0010", {ifm_rd_start, wgt_rd_start, core_start, ofm_wr_start}); end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL allzero_done: got %b want 1", ap_done); end
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
    endtask

    task automatic test_back_to_back();
        job_t e;
        set_job('{ia: 64'hA000, wa: 64'hB000, oa: 64'hC000, isz: 32'd16, wsz: 32'd16,
                  osz: 32'd16, ci: 32'd7, co: 32'd8});
        ap_start = 1'b1;
        tick();
        tick();                                         // cycle 2, LOAD entry
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_a_latched: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (obs !== e) begin bad++; $display("FAIL b2b_a_latched: got %h want %h", obs, e); end
        end
        ifm_rd_done = 1'b1;
        wgt_rd_done = 1'b1;
        tick();                                         // cycle 3
        ifm_rd_done = 1'b0;
        wgt_rd_done = 1'b0;
        total++; if (core_start !== 1'b1) begin bad++; $display("FAIL b2b_a_core_start: got %b want 1", core_start); end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        total++; if (ap_done !== 1'b0) begin bad++; $display("FAIL b2b_a_wait_ofm: got %b want 0", ap_done); end
        ofm_wr_done = 1'b1;
        tick();
        ofm_wr_done = 1'b0;
        total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL b2b_a_done: got %b want 1", ap_done); end
        set_job('{ia: 64'hD000, wa: 64'hE000, oa: 64'hF000, isz: 32'd8, wsz: 32'd8,
                  osz: 32'd8, ci: 32'd9, co: 32'd10});
        tick();
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        total++; if ({ap_idle, ap_done} !== 2'b10) begin bad++; $display("FAIL b2b_idle: got %b want 10", {ap_idle, ap_done}); end
        ofm_wr_done = 1'b1;
        core_done = 1'b1;
        tick();
        ofm_wr_done = 1'b0;
        core_done = 1'b0;
        total++; if (ap_ready !== 1'b1) begin bad++; $display("FAIL b2b_relatch: got %b want 1", ap_ready); end
        ap_start = 1'b0;
        tick();
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_b_latched: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (obs !== e) begin bad++; $display("FAIL b2b_b_latched: got %h want %h", obs, e); end
        end
        ifm_rd_done = 1'b1;
        wgt_rd_done = 1'b1;
        tick();
        ifm_rd_done = 1'b0;
        wgt_rd_done = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        total++; if (ap_done !== 1'b0) begin bad++; $display("FAIL b2b_stray_ofm: got %b want 0", ap_done); end
        ofm_wr_done = 1'b1;
        tick();
        ofm_wr_done = 1'b0;
        total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL b2b_b_done: got %b want 1", ap_done); end
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        job_t e;
        set_job('{ia: 64'h11000, wa: 64'h12000, oa: 64'h13000, isz: 32'd4, wsz: 32'd4,
                  osz: 32'd4, ci: 32'd1, co: 32'd1});
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        void'(exp_q.pop_front());
        tick();
        ARESET = 1'b1;
        #1;
        total++; if ({ap_idle, ap_done, ap_ready} !== 3'b100) begin bad++; $display("FAIL midrst_flags: got %b want 100", {ap_idle, ap_done, ap_ready}); end
        total++; if (obs !== '0) begin bad++; $display("FAIL midrst_latched: got %h want 0", obs); end
        tick();
        tick();
        ARESET = 1'b0;
        tick();
        set_job('{ia: 64'h21000, wa: 64'h22000, oa: 64'h23000, isz: 32'd12, wsz: 32'd0,
                  osz: 32'd20, ci: 32'd2, co: 32'd4});
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        total++; if (ap_ready !== 1'b1) begin bad++; $display("FAIL midrst_restart: got %b want 1", ap_ready); end
        tick();
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL midrst_latched2: scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (obs !== e) begin bad++; $display("FAIL midrst_latched2: got %h want %h", obs, e); end
        end
        ifm_rd_done = 1'b1;
        tick();
        ifm_rd_done = 1'b0;
        core_done = 1'b1;
        ofm_wr_done = 1'b1;
        tick();
        core_done = 1'b0;
        ofm_wr_done = 1'b0;
        total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL midrst_done: got %b want 1", ap_done); end
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
    endtask

    task automatic test_watchdog();
        set_job('{ia: 64'h31000, wa: 64'h32000, oa: 64'h33000, isz: 32'd4, wsz: 32'd4,
                  osz: 32'd4, ci: 32'd1, co: 32'd1});
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        void'(exp_q.pop_front());
        ifm_rd_done = 1'b1;
        wgt_rd_done = 1'b1;
        tick();                                         // first COMPUTE cycle
        ifm_rd_done = 1'b0;
        wgt_rd_done = 1'b0;
        ofm_wr_done = 1'b1;
        tick();                                         // second COMPUTE cycle
        ofm_wr_done = 1'b0;
`ifdef KRNL_ACC_CTRL_TIMEOUT_EN
        repeat (48) tick();                             // 50th COMPUTE cycle
        total++; if ({ap_done, err_timeout} !== 2'b00) begin bad++; $display("FAIL wd_early: got %b want 00", {ap_done, err_timeout}); end
        tick();
        total++; if ({ap_done, err_timeout} !== 2'b11) begin bad++; $display("FAIL wd_fire: got %b want 11", {ap_done, err_timeout}); end
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        total++; if ({ap_idle, err_timeout} !== 2'b11) begin bad++; $display("FAIL wd_sticky: got %b want 11", {ap_idle, err_timeout}); end
        set_job('{ia: 64'h41000, wa: 64'h42000, oa: 64'h43000, isz: 32'd0, wsz: 32'd0,
                  osz: 32'd0, ci: 32'd1, co: 32'd1});
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        void'(exp_q.pop_front());
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL wd_clear: got %b want 0", err_timeout); end
        tick();
`else
        repeat (60) tick();
        total++; if ({ap_done, err_timeout} !== 2'b00) begin bad++; $display("FAIL nowd_wait: got %b want 00", {ap_done, err_timeout}); end
`endif
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        total++; if (ap_done !== 1'b1) begin bad++; $display("FAIL wd_job_done: got %b want 1", ap_done); end
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1;
        ap_start = 1'b0;
        ap_continue = 1'b0;
        cfg_ci = '0;
        cfg_co = '0;
        ifm_size = '0;
        wgt_size = '0;
        ofm_size = '0;
        ifm_addr_base = '0;
        wgt_addr_base = '0;
        ofm_addr_base = '0;
        ifm_rd_done = 1'b0;
        wgt_rd_done = 1'b0;
        ofm_wr_done = 1'b0;
        core_done = 1'b0;
        test_reset();
        test_nominal();
        test_zero_sizes();
        test_back_to_back();
        test_reset_mid_job();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 1000000");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/krnl_acc_ctrl_fsm.md
Name: krnl_acc_ctrl_fsm

Overview:
Kernel sequencer that sits directly downstream of the AXI-lite control slave. It consumes ap_start/ap_continue and the CFG/size/base-address registers, and implements ap_ctrl_chain semantics by driving ap_done/ap_idle/ap_ready back to the slave. It latches one job's configuration, launches the IFM and WGT read DMAs, then launches the conv core and the OFM write DMA. It waits for every launched engine to finish before signalling done.

Parameters:
ADDR_W, 64, width of DDR base addresses
SIZE_W, 32, width of byte-size and cfg fields
TIMEOUT_CYCLES, 32'd1000000, watchdog limit per wait state (used only with KRNL_ACC_CTRL_TIMEOUT_EN)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
ap_start  in  1  level from control slave; held until ap_ready
ap_continue  in  1  one-cycle pulse from control slave
ap_done  out  1  job complete; held until ap_continue
ap_idle  out  1  sequencer idle
ap_ready  out  1  one-cycle pulse: job config accepted
cfg_ci, cfg_co  in  SIZE_W  channel config
ifm_size, wgt_size, ofm_size  in  SIZE_W  byte counts
ifm_addr_base, wgt_addr_base, ofm_addr_base  in  ADDR_W  DDR bases
ifm_rd_start, wgt_rd_start, ofm_wr_start  out  1  one-cycle launch pulses
ifm_rd_addr, wgt_rd_addr, ofm_wr_addr  out  ADDR_W  latched bases
ifm_rd_size, wgt_rd_size, ofm_wr_size  out  SIZE_W  latched sizes
ifm_rd_done, wgt_rd_done, ofm_wr_done  in  1  one-cycle completion pulses
core_start  out  1  one-cycle launch pulse to conv core
core_ci, core_co  out  SIZE_W  latched cfg
core_done  in  1  one-cycle completion pulse
err_timeout  out  1  sticky watchdog flag (tied 0 without macro)

Behaviour:
- Reset (async, ARESET=1): state=IDLE; ap_idle=1; all other outputs 0, including latched addr/size/cfg outputs and sticky flags.
- States: IDLE, LATCH, LOAD, COMPUTE, DONE.
- IDLE: when ap_start=1, go to LATCH; ap_idle falls on that edge.
- LATCH (1 cycle): register all cfg/size/base inputs into the output regs; ap_ready=1 for exactly this cycle; clear sticky done flags; go to LOAD.
- LOAD entry cycle: pulse ifm_rd_start if ifm_size!=0 and wgt_rd_start if wgt_size!=0, in the same cycle.
  - A zero-size engine is not started; its sticky done flag is preset to 1.
  - Sticky flags set on ifm_rd_done/wgt_rd_done.
  - Leave for COMPUTE on the first cycle both flags are 1, including a done pulse arriving in the cycle both become set. Zero-cycle transit is allowed when both sizes are 0.
- COMPUTE entry cycle: core_start pulses unconditionally; ofm_wr_start pulses if ofm_size!=0, otherwise its flag is preset.
  - Sticky flags set on core_done and ofm_wr_done; the two may arrive in either order or the same cycle.
  - Both flags set -> DONE.
- DONE: ap_done=1 (registered, asserted on first DONE cycle). ap_continue while in DONE -> IDLE next cycle; ap_done and ap_idle update on that edge.
- Done pulses received outside their wait state are ignored and never carried into the next job.
- ap_continue outside DONE is ignored.
- ap_start held high across DONE->IDLE starts the next job immediately (back-to-back).
- Latched outputs stay stable from LATCH until the next LATCH. Input register changes mid-job have no effect.
- Reset mid-job: immediate return to IDLE with reset values; downstream engines share ARESET.
- Latency: ap_start high at cycle 0 -> ap_ready at cycle 1 -> start pulses at cycle 2.

Optional Feature:
KRNL_ACC_CTRL_TIMEOUT_EN:
- Defined: a 32-bit counter clears on entry to LOAD and COMPUTE and increments every cycle in those states. On reaching TIMEOUT_CYCLES, err_timeout is set (sticky until the next LATCH) and the state goes to DONE, so the host is not hung.
- Undefined: no counter; err_timeout is constant 0; LOAD/COMPUTE wait indefinitely.

Test Plan:
- Reset then idle: ARESET pulse -> ap_idle=1, ap_done=0, all start pulses 0, latched addrs 0.
- Nominal job: bases 0x1000/0x2000/0x3000, sizes 256/64/128, ap_start=1; ifm_rd_done after 10 cycles, wgt_rd_done after 20 cycles -> ap_ready at cycle 1; ifm/wgt starts at cycle 2; core_start+ofm_wr_start one cycle after wgt_rd_done; core_done and ofm_wr_done in the same cycle -> ap_done next cycle, held until an ap_continue pulse, then ap_idle=1.
- Zero sizes: wgt_size=0, ofm_size=0 -> wgt_rd_start and ofm_wr_start never pulse; job completes on ifm_rd_done + core_done alone.
- Config change mid-job: write ifm_addr_base=0xDEAD during LOAD -> ifm_rd_addr stays 0x1000.
- Back-to-back: ap_start kept high; ap_continue in DONE -> LATCH within 2 cycles; a stray ofm_wr_done pulsed during IDLE must not complete the second job early.
- With KRNL_ACC_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=50: withhold core_done -> err_timeout=1 and ap_done=1 after 50 COMPUTE cycles.
